regfile_2r1w_param: RTL and testbench

REGFILE_2R1W_PARAM -- requirements
Module: regfile_2r1w_param

---
 rtl/regfile_2r1w_param.sv | 141 ++++++++++++++
 tb/tb_regfile_2r1w_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w_param.sv
// Parameterised register file with two registered read ports and one write port.
// A clear sweep writes RESET_VALUE to every register, one register per cycle.
//
// Ports:
//   clock              rising-edge clock
//   reset              synchronous active-high reset
//   wr_regnum/wr_data  write register number and data
//   write_enable       write request (ignored while busy or when out of range)
//   rd0_regnum/rd1_regnum  read register numbers
//   rd0_data/rd1_data  registered read data, write-first bypass
//   clear_req          starts a clear sweep (ignored while busy)
//   busy               high while the sweep runs
//   clear_done         one-cycle pulse after the final sweep write
//
// Optional feature: define REGFILE_R0_ZERO_EN to hard-wire register 0 to read 0.
module regfile_2r1w_param #(
  parameter int unsigned       WIDTH       = 16,
  parameter int unsigned       DEPTH       = 16,
  parameter int unsigned       ADDR_W      = 4,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_regnum,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] rd0_regnum,
  input  logic [ADDR_W-1:0] rd1_regnum,
  output logic [WIDTH-1:0]  rd0_data,
  output logic [WIDTH-1:0]  rd1_data,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Zero = 1'b1;
`else
  localparam bit R0Zero = 1'b0;
`endif

  logic [WIDTH-1:0]  mem_q [DEPTH];
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  rd0_q, rd0_d, rd1_q, rd1_d;

  // Single internal write port shared by user writes and the sweep.
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;

  function automatic logic in_range(input logic [ADDR_W-1:0] n);
    return 32'(n) < DEPTH;
  endfunction

  function automatic logic is_r0(input logic [ADDR_W-1:0] n);
    return R0Zero && (n == '0);
  endfunction

  // Write-first read: a same-edge write (user or sweep) wins over stored data.
  function automatic logic [WIDTH-1:0] rd_next(input logic [ADDR_W-1:0] n,
                                               input logic wen_f,
                                               input logic [ADDR_W-1:0] waddr_f,
                                               input logic [WIDTH-1:0] wdata_f);
    if (!in_range(n) || is_r0(n)) begin
      return '0;
    end else if (wen_f && (waddr_f == n)) begin
      return wdata_f;
    end else begin
      return mem_q[n];
    end
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wen     = 1'b0;
    waddr   = wr_regnum;
    wdata   = wr_data;
    unique case (state_q)
      StIdle: begin
        if (write_enable && in_range(wr_regnum) && !is_r0(wr_regnum)) begin
          wen = 1'b1;
        end
        // A coincident write completes now; the sweep starts on the next edge.
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        wen   = 1'b1;
        waddr = cnt_q;
        wdata = RESET_VALUE;
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LastIdx) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    rd0_d = rd_next(rd0_regnum, wen, waddr, wdata);
    rd1_d = rd_next(rd1_regnum, wen, waddr, wdata);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= RESET_VALUE;
      end
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      if (wen) begin
        mem_q[waddr] <= wdata;
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign rd0_data   = rd0_q;
  assign rd1_data   = rd1_q;
  assign busy       = (state_q == StClear);
  assign clear_done = done_q;

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Directed testbench for regfile_2r1w_param: default 16x16 instance plus a DEPTH=12 instance.
module tb_regfile_2r1w_param;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  wr_regnum, rd0_regnum, rd1_regnum;
  logic [15:0] wr_data;
  logic        write_enable, clear_req;
  logic [15:0] rd0_data, rd1_data;
  logic        busy, clear_done;

  logic [3:0]  b_wr_regnum, b_rd0_regnum, b_rd1_regnum;
  logic [15:0] b_wr_data;
  logic        b_write_enable, b_clear_req;
  logic [15:0] b_rd0_data, b_rd1_data;
  logic        b_busy, b_clear_done;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock = ~clock;

  regfile_2r1w_param u_dut (
    .clock        (clock),
    .reset        (reset),
    .wr_regnum    (wr_regnum),
    .wr_data      (wr_data),
    .write_enable (write_enable),
    .rd0_regnum   (rd0_regnum),
    .rd1_regnum   (rd1_regnum),
    .rd0_data     (rd0_data),
    .rd1_data     (rd1_data),
    .clear_req    (clear_req),
    .busy         (busy),
    .clear_done   (clear_done)
  );

  regfile_2r1w_param #(
    .WIDTH  (16),
    .DEPTH  (12),
    .ADDR_W (4)
  ) u_dut12 (
    .clock        (clock),
    .reset        (reset),
    .wr_regnum    (b_wr_regnum),
    .wr_data      (b_wr_data),
    .write_enable (b_write_enable),
    .rd0_regnum   (b_rd0_regnum),
    .rd1_regnum   (b_rd1_regnum),
    .rd0_data     (b_rd0_data),
    .rd1_data     (b_rd1_data),
    .clear_req    (b_clear_req),
    .busy         (b_busy),
    .clear_done   (b_clear_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] n, input logic [15:0] d);
    write_enable = 1'b1;
    wr_regnum    = n;
    wr_data      = d;
    step();
    write_enable = 1'b0;
  endtask

  logic [15:0] exp0;

  initial begin
    reset = 1'b1;
    wr_regnum = '0; wr_data = '0; write_enable = 1'b0;
    rd0_regnum = '0; rd1_regnum = '0; clear_req = 1'b0;
    b_wr_regnum = '0; b_wr_data = '0; b_write_enable = 1'b0;
    b_rd0_regnum = '0; b_rd1_regnum = '0; b_clear_req = 1'b0;
    step();
    step();
    check_eq("rst_rd0", rd0_data, 16'h0);
    check_eq("rst_rd1", rd1_data, 16'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", clear_done, 1'b0);
    reset = 1'b0;

    // Write then read next cycle.
    wr(4'd3, 16'h1234);
    rd0_regnum = 4'd3;
    step();
    check_eq("rd_reg3", rd0_data, 16'h1234);

    // Same-cycle write and dual read of reg5: write-first bypass on both ports.
    rd0_regnum = 4'd5;
    rd1_regnum = 4'd5;
    wr(4'd5, 16'hBEEF);
    check_eq("byp_rd0", rd0_data, 16'hBEEF);
    check_eq("byp_rd1", rd1_data, 16'hBEEF);

    // Bypass to register 0.
    rd0_regnum = 4'd0;
    wr(4'd0, 16'h0F0F);
    check_eq("byp_r0", rd0_data, R0Z ? 16'h0 : 16'h0F0F);

    // Fill all registers; reg0 gets 0xFFFF.
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), (i == 0) ? 16'hFFFF : 16'hA000 + 16'(i));
    end
    for (int i = 0; i < 16; i++) begin
      rd0_regnum = 4'(i);
      rd1_regnum = 4'(15 - i);
      step();
      exp0 = (i == 0) ? (R0Z ? 16'h0 : 16'hFFFF) : 16'hA000 + 16'(i);
      check_eq($sformatf("fill_rd0_%0d", i), rd0_data, exp0);
      exp0 = (i == 15) ? (R0Z ? 16'h0 : 16'hFFFF) : 16'hA000 + 16'(15 - i);
      check_eq($sformatf("fill_rd1_%0d", 15 - i), rd1_data, exp0);
    end

    // clear_req with a coincident write to reg7: the write lands, then the sweep clears it.
    clear_req    = 1'b1;
    write_enable = 1'b1;
    wr_regnum    = 4'd7;
    wr_data      = 16'h7777;
    rd0_regnum   = 4'd7;
    step();
    check_eq("clr_start_busy", busy, 1'b1);
    check_eq("clr_start_done", clear_done, 1'b0);
    check_eq("clr_start_rd7", rd0_data, 16'h7777);

    // Sweep: writes to reg2 and clear_req must be ignored; reads stay live.
    for (int k = 1; k <= 16; k++) begin
      clear_req    = (k < 16);
      write_enable = 1'b1;
      wr_regnum    = 4'd2;
      wr_data      = 16'h5555;
      rd0_regnum   = 4'(k - 1);
      rd1_regnum   = 4'd15;
      step();
      check_eq($sformatf("swp_busy_%0d", k), busy, (k < 16));
      check_eq($sformatf("swp_done_%0d", k), clear_done, (k == 16));
      check_eq($sformatf("swp_rd0_%0d", k), rd0_data, 16'h0);
      check_eq($sformatf("swp_rd1_%0d", k), rd1_data, (k == 16) ? 16'h0 : 16'hA00F);
    end
    clear_req    = 1'b0;
    write_enable = 1'b0;
    step();
    check_eq("post_done", clear_done, 1'b0);
    check_eq("post_busy", busy, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rd0_regnum = 4'(i);
      step();
      check_eq($sformatf("clr_rd_%0d", i), rd0_data, 16'h0);
    end

    // Reset in the middle of a sweep.
    wr(4'd4, 16'h4444);
    wr(4'd9, 16'h9999);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check_eq("mid_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", clear_done, 1'b0);
    reset = 1'b0;
    rd0_regnum = 4'd9;
    rd1_regnum = 4'd4;
    step();
    check_eq("abort_done2", clear_done, 1'b0);
    check_eq("abort_rd9", rd0_data, 16'h0);
    check_eq("abort_rd4", rd1_data, 16'h0);

    // DEPTH=12 instance: out-of-range write discarded, out-of-range read returns 0.
    b_write_enable = 1'b1;
    b_wr_regnum    = 4'd11;
    b_wr_data      = 16'hABCD;
    step();
    b_wr_regnum    = 4'd13;
    b_wr_data      = 16'h1313;
    b_rd0_regnum   = 4'd13;
    b_rd1_regnum   = 4'd11;
    step();
    check_eq("d12_byp13", b_rd0_data, 16'h0);
    check_eq("d12_rd11", b_rd1_data, 16'hABCD);
    b_write_enable = 1'b0;
    step();
    check_eq("d12_rd13", b_rd0_data, 16'h0);
    check_eq("d12_rd11b", b_rd1_data, 16'hABCD);
    for (int i = 1; i < 11; i++) begin
      b_rd0_regnum = 4'(i);
      step();
      check_eq($sformatf("d12_rd_%0d", i), b_rd0_data, 16'h0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
